// File: rtl/subterranean_stream_defs.sv
// Shared definitions for the Subterranean stream buffer: drain-mode encoding
// and the ceiling-log2 helper used to size pointers and counters.
package subterranean_stream_defs;

  typedef enum logic {
    MODE_WORD = 1'b0,
    MODE_BYTE = 1'b1
  } drain_mode_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/subterranean_stream_buffer_if.sv
// Input and output stream handshakes of the Subterranean stream buffer.
// The buffer is the slave of both streams; the surrounding datapath is the master.
interface subterranean_stream_buffer_if
  import subterranean_stream_defs::*;
#(
  parameter int G_WORD_BYTES = 4,
  parameter int G_SIZE_BITS  = clog2(G_WORD_BYTES + 1)
);

  logic [8*G_WORD_BYTES-1:0] din;
  logic [G_SIZE_BITS-1:0]    din_size;
  logic                      din_last;
  logic                      din_valid;
  logic                      din_ready;
  logic [8*G_WORD_BYTES-1:0] dout;
  logic [G_SIZE_BITS-1:0]    dout_size;
  logic                      dout_last;
  logic                      dout_valid;
  logic                      dout_ready;

  modport slave (
    input  din, din_size, din_last, din_valid, dout_ready,
    output din_ready, dout, dout_size, dout_last, dout_valid
  );

  modport master (
    output din, din_size, din_last, din_valid, dout_ready,
    input  din_ready, dout, dout_size, dout_last, dout_valid
  );

endinterface

// File: rtl/subterranean_stream_fifo_mem.sv
// Entry storage for the stream buffer: one synchronous write port and an
// asynchronous read port. Storage is deliberately not reset.
module subterranean_stream_fifo_mem #(
  parameter int G_DEPTH     = 2,
  parameter int G_WIDTH     = 36,
  parameter int G_ADDR_BITS = 1
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [G_ADDR_BITS-1:0] waddr,
  input  logic [G_WIDTH-1:0]     wdata,
  input  logic [G_ADDR_BITS-1:0] raddr,
  output logic [G_WIDTH-1:0]     rdata
);

  logic [G_WIDTH-1:0] mem_r [G_DEPTH];

  // entry write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/subterranean_stream_buffer.sv
// Input-side FIFO for the Subterranean datapath, draining either whole words
// or single bytes (LSB first) toward the permutation core.
module subterranean_stream_buffer
  import subterranean_stream_defs::*;
#(
  parameter int G_WORD_BYTES = 4,
  parameter int G_DEPTH      = 2,
  parameter int G_SIZE_BITS  = clog2(G_WORD_BYTES + 1),
  parameter int G_CNT_BITS   = clog2(G_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  flush,
  input  logic                  mode,
  subterranean_stream_buffer_if.slave bus,
  output logic [G_CNT_BITS-1:0] occupancy
);

  localparam int DW        = 8 * G_WORD_BYTES;
  localparam int EW        = DW + G_SIZE_BITS + 1;
  localparam int PTR_BITS  = clog2(G_DEPTH);

  logic [PTR_BITS-1:0]    wr_ptr_r, rd_ptr_r;
  logic [G_CNT_BITS-1:0]  occ_r;
  logic [G_SIZE_BITS-1:0] off_r;
  drain_mode_e            mode_r;

  logic [EW-1:0]          wdata_s, rdata_s;
  logic [DW-1:0]          masked_s, head_data_s;
  logic [G_SIZE_BITS-1:0] size_clamp_s, head_size_s;
  logic                   head_last_s;
  logic [7:0]             head_byte_s;
  logic                   active_s, hs_s, pop_s, push_s, ready_s, byte_end_s;

  // clamp incoming size and zero every byte at or beyond it
  always_comb begin
    size_clamp_s = (bus.din_size > G_SIZE_BITS'(G_WORD_BYTES)) ?
                   G_SIZE_BITS'(G_WORD_BYTES) : bus.din_size;
    masked_s = '0;
    for (int i = 0; i < G_WORD_BYTES; i++) begin
      masked_s[8*i +: 8] = bus.din[8*i +: 8] & {8{G_SIZE_BITS'(i) < size_clamp_s}};
    end
    wdata_s = {bus.din_last, size_clamp_s, masked_s};
  end

  subterranean_stream_fifo_mem #(
    .G_DEPTH     (G_DEPTH),
    .G_WIDTH     (EW),
    .G_ADDR_BITS (PTR_BITS)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (wdata_s),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  assign {head_last_s, head_size_s, head_data_s} = rdata_s;

  // head byte select, handshake and pop/push decisions
  always_comb begin
    head_byte_s = 8'h00;
    for (int i = 0; i < G_WORD_BYTES; i++) begin
      head_byte_s = head_byte_s | (head_data_s[8*i +: 8] & {8{off_r == G_SIZE_BITS'(i)}});
    end
    // a size-0 entry ends on its single beat
    byte_end_s = (head_size_s == '0) || ((off_r + G_SIZE_BITS'(1)) >= head_size_s);
    active_s   = !arstn && (occ_r != '0);
    hs_s       = active_s && bus.dout_ready;
    pop_s      = hs_s && ((mode_r == MODE_WORD) || byte_end_s);
    ready_s    = !arstn && !flush && ((occ_r < G_CNT_BITS'(G_DEPTH)) || pop_s);
    push_s     = bus.din_valid && ready_s;
  end

  // output beat formatting for the active drain mode
  always_comb begin
    bus.dout       = '0;
    bus.dout_size  = '0;
    bus.dout_last  = 1'b0;
    bus.dout_valid = 1'b0;
    if (active_s) begin
      bus.dout_valid = 1'b1;
      case (mode_r)
        MODE_WORD: begin
          bus.dout      = head_data_s;
          bus.dout_size = head_size_s;
          bus.dout_last = head_last_s;
        end
        MODE_BYTE: begin
          bus.dout      = DW'(head_byte_s);
          bus.dout_size = (head_size_s == '0) ? G_SIZE_BITS'(0) : G_SIZE_BITS'(1);
          bus.dout_last = head_last_s && byte_end_s;
        end
        default: begin
          bus.dout_valid = 1'b0;
        end
      endcase
    end else begin
      bus.dout_valid = 1'b0;
    end
  end

  assign bus.din_ready = ready_s;
  assign occupancy     = occ_r;

  // pointers, occupancy, byte offset and latched drain mode
  always_ff @(posedge clk) begin
    if (arstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      off_r    <= '0;
      mode_r   <= MODE_WORD;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      off_r    <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + G_CNT_BITS'(1);
        2'b01:   occ_r <= occ_r - G_CNT_BITS'(1);
        default: occ_r <= occ_r;
      endcase
      if (pop_s) begin
        off_r <= '0;
      end else if (hs_s) begin
        off_r <= off_r + G_SIZE_BITS'(1);
      end
      // mode only follows the input while nothing is buffered
      if (occ_r == '0) begin
        mode_r <= drain_mode_e'(mode);
      end
    end
  end

endmodule

// File: tb/tb_subterranean_stream_buffer.sv
// Directed scoreboard bench for subterranean_stream_buffer (default parameters).
module tb_subterranean_stream_buffer;

  logic       clk = 1'b0;
  logic       arstn;
  logic       flush;
  logic       mode;
  logic [1:0] occupancy;

  subterranean_stream_buffer_if bus ();

  subterranean_stream_buffer dut (
    .clk       (clk),
    .arstn     (arstn),
    .flush     (flush),
    .mode      (mode),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [35:0] exp_q [$];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [2:0] s, input logic l);
    exp_q.push_back({l, s, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] s, input logic l);
    bit done;
    done = 1'b0;
    tick();
    bus.din       = d;
    bus.din_size  = s;
    bus.din_last  = l;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.din_ready === 1'b1) begin
        tick();
        done = 1'b1;
      end
    end
    bus.din_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: din_ready never 1 for %h", d);
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && occupancy == 2'd0) ok = 1'b1;
    end
    check({name, "_done"}, 36'(ok), 36'd1);
    check({name, "_occ"}, 36'(occupancy), 36'd0);
    check({name, "_valid"}, 36'(bus.dout_valid), 36'd0);
  endtask

  // scoreboard monitor: every output handshake is matched against the queue
  always @(negedge clk) begin
    if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h, expected no beat",
                 {bus.dout_last, bus.dout_size, bus.dout});
      end else begin
        check("beat", {bus.dout_last, bus.dout_size, bus.dout}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    arstn          = 1'b1;
    flush          = 1'b0;
    mode           = 1'b0;
    bus.din        = 32'h0;
    bus.din_size   = 3'd0;
    bus.din_last   = 1'b0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_din_ready", 36'(bus.din_ready), 36'd0);
    check("rst_dout_valid", 36'(bus.dout_valid), 36'd0);
    check("rst_dout", {bus.dout_last, bus.dout_size, bus.dout}, 36'd0);
    check("rst_occ", 36'(occupancy), 36'd0);
    tick();
    arstn = 1'b0;
    @(negedge clk);
    check("rel_din_ready", 36'(bus.din_ready), 36'd1);

    // word passthrough, masking and size clamp
    bus.dout_ready = 1'b1;
    expect_beat(32'hDDCCBBAA, 3'd4, 1'b0);
    push(32'hDDCCBBAA, 3'd4, 1'b0);
    @(negedge clk);
    check("lat1_valid", 36'(bus.dout_valid), 36'd1);
    expect_beat(32'h00001122, 3'd2, 1'b1);
    push(32'h00001122, 3'd2, 1'b1);
    @(negedge clk);
    check("lat2_valid", 36'(bus.dout_valid), 36'd1);
    expect_beat(32'h00FFFFFF, 3'd3, 1'b0);
    push(32'hFFFFFFFF, 3'd3, 1'b0);
    expect_beat(32'h44332211, 3'd4, 1'b0);
    push(32'h44332211, 3'd7, 1'b0);
    drain("word");

    // backpressure, full, then simultaneous pop and push
    bus.dout_ready = 1'b0;
    expect_beat(32'h01020304, 3'd4, 1'b0);
    expect_beat(32'h05060708, 3'd4, 1'b0);
    expect_beat(32'h090A0B0C, 3'd4, 1'b1);
    tick();
    bus.din = 32'h01020304; bus.din_size = 3'd4; bus.din_last = 1'b0; bus.din_valid = 1'b1;
    @(negedge clk);
    check("bp_ready0", 36'(bus.din_ready), 36'd1);
    tick();
    bus.din = 32'h05060708;
    @(negedge clk);
    check("bp_occ1", 36'(occupancy), 36'd1);
    check("bp_ready1", 36'(bus.din_ready), 36'd1);
    tick();
    bus.din = 32'h090A0B0C; bus.din_last = 1'b1;
    @(negedge clk);
    check("bp_occ2", 36'(occupancy), 36'd2);
    check("bp_full_ready", 36'(bus.din_ready), 36'd0);
    tick();
    @(negedge clk);
    check("bp_occ2_hold", 36'(occupancy), 36'd2);
    tick();
    bus.dout_ready = 1'b1;
    @(negedge clk);
    check("bp_poppush_ready", 36'(bus.din_ready), 36'd1);
    tick();
    bus.din_valid = 1'b0;
    @(negedge clk);
    check("bp_occ_after_both", 36'(occupancy), 36'd2);
    drain("bp");

    // byte drain
    mode = 1'b1;
    tick();
    expect_beat(32'h00000011, 3'd1, 1'b0);
    expect_beat(32'h00000022, 3'd1, 1'b0);
    expect_beat(32'h00000033, 3'd1, 1'b1);
    push(32'h00332211, 3'd3, 1'b1);
    drain("byte");

    // empty-block marker in byte mode, then word mode
    expect_beat(32'h0, 3'd0, 1'b1);
    push(32'h12345678, 3'd0, 1'b1);
    drain("empty_byte");
    mode = 1'b0;
    tick();
    expect_beat(32'h0, 3'd0, 1'b1);
    push(32'h12345678, 3'd0, 1'b1);
    drain("empty_word");

    // mode change mid-message is ignored until drained
    mode = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    expect_beat(32'h000000AA, 3'd1, 1'b0);
    expect_beat(32'h000000BB, 3'd1, 1'b0);
    expect_beat(32'h000000CC, 3'd1, 1'b0);
    expect_beat(32'h000000DD, 3'd1, 1'b1);
    push(32'h0000BBAA, 3'd2, 1'b0);
    push(32'h0000DDCC, 3'd2, 1'b1);
    tick();
    bus.dout_ready = 1'b1;
    tick();
    mode = 1'b0;
    @(negedge clk);
    check("hold_byte_beat", {bus.dout_last, bus.dout_size, bus.dout}, {1'b0, 3'd1, 32'h000000BB});
    drain("hold");
    expect_beat(32'h0000BBAA, 3'd2, 1'b1);
    push(32'h0000BBAA, 3'd2, 1'b1);
    drain("hold_word");

    // flush mid-message at byte offset 1
    mode = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    push(32'h44332211, 3'd4, 1'b0);
    push(32'h88776655, 3'd4, 1'b1);
    expect_beat(32'h00000011, 3'd1, 1'b0);
    tick();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    @(negedge clk);
    check("fl_occ", 36'(occupancy), 36'd2);
    check("fl_offset_beat", {bus.dout_last, bus.dout_size, bus.dout}, {1'b0, 3'd1, 32'h00000022});
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("fl_ready_blocked", 36'(bus.din_ready), 36'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("fl_occ0", 36'(occupancy), 36'd0);
    check("fl_valid0", 36'(bus.dout_valid), 36'd0);
    check("fl_ready1", 36'(bus.din_ready), 36'd1);

    // reset mid-message
    push(32'h44332211, 3'd4, 1'b0);
    push(32'h88776655, 3'd4, 1'b1);
    expect_beat(32'h00000011, 3'd1, 1'b0);
    tick();
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    arstn = 1'b1;
    @(negedge clk);
    check("ar_ready0", 36'(bus.din_ready), 36'd0);
    check("ar_valid0", 36'(bus.dout_valid), 36'd0);
    tick();
    arstn = 1'b0;
    mode  = 1'b0;
    @(negedge clk);
    check("ar_occ0", 36'(occupancy), 36'd0);
    check("ar_ready1", 36'(bus.din_ready), 36'd1);
    bus.dout_ready = 1'b1;
    expect_beat(32'h0000ABCD, 3'd2, 1'b1);
    push(32'h0000ABCD, 3'd2, 1'b1);
    drain("ar_word");

    check("queue_empty", 36'(exp_q.size()), 36'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
